// File: rtl/pred_raw_pkg.sv
// ---------------------------------------------------------------------------
// pred_raw_pkg
// Shared types and constants for the pred_raw scheduler slice.
//   int32_t / int2_t : data and 2-bit select typedefs
//   cfg_ctrl_t       : packed atom control word
//                      {sel_1, sel_2, sel_3, sel_4, rel_opcode}
//   CTRL_NOP         : predicate 0 != 0 is false, so the state is untouched
//   CTRL_CLEAR       : predicate 0 == 0 is true and the update is 0 + 0,
//                      so the state becomes 0
//   sched_state_t    : scheduler FSM states
// ---------------------------------------------------------------------------
package pred_raw_pkg;

    typedef logic [31:0] int32_t;
    typedef logic [1:0]  int2_t;

    typedef struct packed {
        logic  sel_1;
        int2_t sel_2;
        logic  sel_3;
        int2_t sel_4;
        int2_t rel_opcode;
    } cfg_ctrl_t;

    localparam logic [7:0] CTRL_NOP   = 8'hD8;
    localparam logic [7:0] CTRL_CLEAR = 8'hDB;

    typedef enum logic [1:0] {
        ST_CLR0,
        ST_CLR1,
        ST_RUN
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts at ptr+1 and
// wraps, so the requester granted last time has the lowest priority.
// The pointer register itself lives in the parent.
//   req     in  N   request vector
//   ptr     in  W   index of the previously granted requester
//   gnt     out N   one-hot grant (all zero when req is zero)
//   gnt_idx out W   binary index of the grant (0 when nothing is granted)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    // Walk the N positions after ptr and latch onto the first requester.
    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = W'(idx);
            end
        end
    end

endmodule

// File: rtl/pred_raw_sched.sv
// ---------------------------------------------------------------------------
// pred_raw_sched
// Shares one external pred_raw stateful atom between NUM_REQ requesters.
// A per-requester config table supplies constants and control; the granted
// requester's packet fields plus its config are driven to the atom in the
// grant cycle. Results are tagged with the owner ID one cycle after the atom
// registers them. After reset the atom is driven with CLEAR for two cycles;
// whenever nothing is granted it is driven with NOP.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   en                         grants allowed when 1
//   req_valid / req_ready      per-requester handshake (ready is one-hot)
//   req_pkt_1 / req_pkt_2      per-requester packet fields, slice i=[32*i+:32]
//   cfg_we, cfg_id, cfg_cons_1, cfg_cons_2, cfg_ctrl   config table write
//   atom_*  (out)              atom inputs
//   atom_write / atom_read     atom outputs (new / old state)
//   resp_valid, resp_id, resp_write, resp_read         tagged result
// ---------------------------------------------------------------------------
module pred_raw_sched
    import pred_raw_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_pkt_1,
    input  logic [NUM_REQ*32-1:0] req_pkt_2,
    input  logic                  cfg_we,
    input  logic [ID_W-1:0]       cfg_id,
    input  logic [31:0]           cfg_cons_1,
    input  logic [31:0]           cfg_cons_2,
    input  logic [7:0]            cfg_ctrl,
    output logic [31:0]           atom_pkt_1,
    output logic [31:0]           atom_pkt_2,
    output logic [31:0]           atom_cons_1,
    output logic [31:0]           atom_cons_2,
    output logic                  atom_sel_1,
    output logic [1:0]            atom_sel_2,
    output logic                  atom_sel_3,
    output logic [1:0]            atom_sel_4,
    output logic [1:0]            atom_rel_opcode,
    input  logic [31:0]           atom_write,
    input  logic [31:0]           atom_read,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_write,
    output logic [31:0]           resp_read
);

    sched_state_t state;
    logic [ID_W-1:0] ptr;

    int32_t    cons1_tab [NUM_REQ];
    int32_t    cons2_tab [NUM_REQ];
    cfg_ctrl_t ctrl_tab  [NUM_REQ];

    int32_t pkt1_arr [NUM_REQ];
    int32_t pkt2_arr [NUM_REQ];

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               grant_ok;
    logic               hs;
    cfg_ctrl_t          drv_ctrl;

    logic            pend_valid;
    logic [ID_W-1:0] pend_id;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign pkt1_arr[g] = req_pkt_1[32*g +: 32];
        assign pkt2_arr[g] = req_pkt_2[32*g +: 32];
    end

    rr_arbiter #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Grants are only offered once the atom has been cleared and en is high.
    assign grant_ok  = (state == ST_RUN) && en;
    assign req_ready = grant_ok ? arb_gnt : '0;
    assign hs        = |(req_valid & req_ready);

    // Clear sequence and round-robin pointer. The pointer only moves on a
    // handshake so an idle cycle does not rotate priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLR0;
            ptr   <= ID_W'(NUM_REQ - 1);
        end else begin
            case (state)
                ST_CLR0: state <= ST_CLR1;
                ST_CLR1: state <= ST_RUN;
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_CLR0;
            endcase
            if (hs) begin
                ptr <= arb_idx;
            end
        end
    end

    // Config table. A write lands at the clock edge, so a grant in the same
    // cycle still sees the previous entry. Out-of-range IDs are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cons1_tab[i] <= '0;
                cons2_tab[i] <= '0;
                ctrl_tab[i]  <= CTRL_NOP;
            end
        end else if (cfg_we && (int'(cfg_id) < NUM_REQ)) begin
            cons1_tab[cfg_id] <= cfg_cons_1;
            cons2_tab[cfg_id] <= cfg_cons_2;
            ctrl_tab[cfg_id]  <= cfg_ctrl;
        end
    end

    // Atom drive: CLEAR while clearing, the granted requester's fields and
    // config on a handshake, otherwise NOP so the state cannot drift.
    always_comb begin
        drv_ctrl    = CTRL_NOP;
        atom_pkt_1  = '0;
        atom_pkt_2  = '0;
        atom_cons_1 = '0;
        atom_cons_2 = '0;
        if (state == ST_CLR0 || state == ST_CLR1) begin
            drv_ctrl = CTRL_CLEAR;
        end else if (hs) begin
            drv_ctrl    = ctrl_tab[arb_idx];
            atom_pkt_1  = pkt1_arr[arb_idx];
            atom_pkt_2  = pkt2_arr[arb_idx];
            atom_cons_1 = cons1_tab[arb_idx];
            atom_cons_2 = cons2_tab[arb_idx];
        end
    end

    assign atom_sel_1      = drv_ctrl.sel_1;
    assign atom_sel_2      = drv_ctrl.sel_2;
    assign atom_sel_3      = drv_ctrl.sel_3;
    assign atom_sel_4      = drv_ctrl.sel_4;
    assign atom_rel_opcode = drv_ctrl.rel_opcode;

    // The atom registers its result at the handshake edge; the owner ID is
    // carried alongside in pend_* and the tagged result is registered one
    // edge later. Reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_id    <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_write <= '0;
            resp_read  <= '0;
        end else begin
            pend_valid <= hs;
            if (hs) begin
                pend_id <= arb_idx;
            end
            resp_valid <= pend_valid;
            if (pend_valid) begin
                resp_id    <= pend_id;
                resp_write <= atom_write;
                resp_read  <= atom_read;
            end
        end
    end

endmodule

// File: tb/tb_pred_raw_sched.sv
// ---------------------------------------------------------------------------
// tb_pred_raw_sched
// Bench for pred_raw_sched with a behavioural pred_raw atom beside it.
// Stimulus pushes the expected tagged result into a queue at grant time; a
// monitor pops and compares whenever resp_valid is seen.
// ---------------------------------------------------------------------------
module tb_pred_raw_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     wr;
        logic [31:0]     rd;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  en;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_pkt_1;
    logic [NUM_REQ*32-1:0] req_pkt_2;
    logic                  cfg_we;
    logic [ID_W-1:0]       cfg_id;
    logic [31:0]           cfg_cons_1;
    logic [31:0]           cfg_cons_2;
    logic [7:0]            cfg_ctrl;
    logic [31:0]           atom_pkt_1, atom_pkt_2, atom_cons_1, atom_cons_2;
    logic                  atom_sel_1, atom_sel_3;
    logic [1:0]            atom_sel_2, atom_sel_4, atom_rel_opcode;
    logic [31:0]           atom_write, atom_read;
    logic                  resp_valid;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_write, resp_read;

    logic        preload_en = 1'b0;
    logic [31:0] preload_val = '0;
    logic [31:0] atom_state = '0;

    int   checks = 0;
    int   errors = 0;
    int   resp_count = 0;
    int   count_mark;
    logic [31:0] exp_state;
    exp_t exp_q[$];
    exp_t mon_e;

    pred_raw_sched #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_pkt_1       (req_pkt_1),
        .req_pkt_2       (req_pkt_2),
        .cfg_we          (cfg_we),
        .cfg_id          (cfg_id),
        .cfg_cons_1      (cfg_cons_1),
        .cfg_cons_2      (cfg_cons_2),
        .cfg_ctrl        (cfg_ctrl),
        .atom_pkt_1      (atom_pkt_1),
        .atom_pkt_2      (atom_pkt_2),
        .atom_cons_1     (atom_cons_1),
        .atom_cons_2     (atom_cons_2),
        .atom_sel_1      (atom_sel_1),
        .atom_sel_2      (atom_sel_2),
        .atom_sel_3      (atom_sel_3),
        .atom_sel_4      (atom_sel_4),
        .atom_rel_opcode (atom_rel_opcode),
        .atom_write      (atom_write),
        .atom_read       (atom_read),
        .resp_valid      (resp_valid),
        .resp_id         (resp_id),
        .resp_write      (resp_write),
        .resp_read       (resp_read)
    );

    always #5 clk = ~clk;

    // Three-way operand mux used by both halves of the atom.
    function automatic logic [31:0] mux3(input logic [1:0] sel, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c);
        if (sel == 2'd0) return a;
        if (sel == 2'd1) return b;
        return c;
    endfunction

    // Behavioural pred_raw: if rel(opt(s), mux) then s = opt(s) + mux.
    function automatic logic [31:0] atom_next(input logic [31:0] s);
        logic [31:0] lhs, rhs, add;
        logic        pred;
        lhs = atom_sel_1 ? 32'd0 : s;
        rhs = mux3(atom_sel_2, atom_pkt_1, atom_pkt_2, atom_cons_1);
        case (atom_rel_opcode)
            2'd0:    pred = (lhs != rhs);
            2'd1:    pred = ($signed(lhs) < $signed(rhs));
            2'd2:    pred = ($signed(lhs) > $signed(rhs));
            default: pred = (lhs == rhs);
        endcase
        add = (atom_sel_3 ? 32'd0 : s) + mux3(atom_sel_4, atom_pkt_1, atom_pkt_2, atom_cons_2);
        return pred ? add : s;
    endfunction

    // The atom registers both the new and the old state at each edge.
    always @(posedge clk) begin
        if (preload_en) begin
            atom_state <= preload_val;
            atom_write <= preload_val;
            atom_read  <= atom_state;
        end else begin
            atom_state <= atom_next(atom_state);
            atom_write <= atom_next(atom_state);
            atom_read  <= atom_state;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic e);
        req_valid = v;
        en        = e;
        #1;
    endtask

    task automatic writeCfg(input logic [ID_W-1:0] id, input logic [31:0] c1,
                            input logic [31:0] c2, input logic [7:0] ctrl);
        cfg_we     = 1'b1;
        cfg_id     = id;
        cfg_cons_1 = c1;
        cfg_cons_2 = c2;
        cfg_ctrl   = ctrl;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pushExp(input logic [ID_W-1:0] id, input logic [31:0] delta);
        exp_t e;
        e.id      = id;
        e.rd      = exp_state;
        exp_state = exp_state + delta;
        e.wr      = exp_state;
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] driven_ctrl();
        return {atom_sel_1, atom_sel_2, atom_sel_3, atom_sel_4, atom_rel_opcode};
    endfunction

    // Monitor: every presented result must match the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            resp_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_resp actual id=%0d write=%0h required no response",
                         resp_id, resp_write);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("resp_id", 32'(resp_id), 32'(mon_e.id));
                checkOutput("resp_write", resp_write, mon_e.wr);
                checkOutput("resp_read", resp_read, mon_e.rd);
            end
        end
    end

    initial begin
        en         = 1'b1;
        req_valid  = '0;
        cfg_we     = 1'b0;
        cfg_id     = '0;
        cfg_cons_1 = '0;
        cfg_cons_2 = '0;
        cfg_ctrl   = '0;
        exp_state  = '0;
        req_pkt_1  = {32'd13, 32'd11, 32'd5, 32'd7};
        req_pkt_2  = {32'd23, 32'd21, 32'd19, 32'd17};
        rst_n      = 1'b0;

        // Reset values
        step();
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_id", 32'(resp_id), 32'd0);
        checkOutput("rst_resp_write", resp_write, 32'd0);
        checkOutput("rst_resp_read", resp_read, 32'd0);
        checkOutput("rst_clear_ctrl", 32'(driven_ctrl()), 32'hDB);
        step();
        rst_n = 1'b1;
        step();
        step();
        checkOutput("idle_nop_ctrl", 32'(driven_ctrl()), 32'hD8);

        // Test 1: preload 55, pulse reset, the atom must be cleared
        preload_val = 32'd55;
        preload_en  = 1'b1;
        step();
        preload_en = 1'b0;
        step();
        checkOutput("preload_read", atom_read, 32'd55);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        writeCfg(2'd0, 32'd0, 32'd1,   8'hCB);
        writeCfg(2'd1, 32'd0, 32'd0,   8'h80);
        writeCfg(2'd2, 32'd0, 32'd1,   8'hCB);
        writeCfg(2'd3, 32'd0, 32'd100, 8'hCB);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("t1_ready", 32'(req_ready), 32'b0001);
        pushExp(2'd0, 32'd1);
        step();
        applyStimulus(4'b0000, 1'b1);
        repeat (3) step();

        // Test 2: single request latency
        applyStimulus(4'b0010, 1'b1);
        checkOutput("t2_ready", 32'(req_ready), 32'b0010);
        pushExp(2'd1, 32'd5);
        step();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("t2_resp_not_yet", 32'(resp_valid), 32'd0);
        step();
        checkOutput("t2_resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("t2_resp_id", 32'(resp_id), 32'd1);
        step();
        checkOutput("t2_resp_one_cycle", 32'(resp_valid), 32'd0);
        repeat (2) step();

        // Move the pointer to 3 so the fairness run starts at requester 0
        applyStimulus(4'b1000, 1'b1);
        checkOutput("t3_pre_ready", 32'(req_ready), 32'b1000);
        pushExp(2'd3, 32'd100);
        step();
        applyStimulus(4'b0000, 1'b1);
        repeat (3) step();

        // Test 3: fairness with all four valid
        count_mark = resp_count;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, 1'b1);
            checkOutput("t3_ready", 32'(req_ready), 32'(1 << (i % 4)));
            if (i >= 2) checkOutput("t3_resp_stream", 32'(resp_valid), 32'd1);
            case (i % 4)
                0:       pushExp(2'd0, 32'd1);
                1:       pushExp(2'd1, 32'd5);
                2:       pushExp(2'd2, 32'd1);
                default: pushExp(2'd3, 32'd100);
            endcase
            step();
        end
        applyStimulus(4'b0000, 1'b1);
        repeat (3) step();
        checkOutput("t3_resp_count", 32'(resp_count - count_mark), 32'd8);

        // Test 4: idle then en=0 with everything valid
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i < 10) ? 4'b0000 : 4'b1111, (i < 10));
            checkOutput("t4_ready", 32'(req_ready), 32'd0);
            checkOutput("t4_resp_valid", 32'(resp_valid), 32'd0);
            checkOutput("t4_atom_read", atom_read, exp_state);
            if (i == 15) checkOutput("t4_nop_ctrl", 32'(driven_ctrl()), 32'hD8);
            step();
        end
        applyStimulus(4'b0000, 1'b1);
        step();

        // Test 5: config write colliding with a grant to the same entry
        cfg_we     = 1'b1;
        cfg_id     = 2'd2;
        cfg_cons_1 = 32'd0;
        cfg_cons_2 = 32'd9;
        cfg_ctrl   = 8'hCB;
        applyStimulus(4'b0100, 1'b1);
        checkOutput("t5_ready_a", 32'(req_ready), 32'b0100);
        pushExp(2'd2, 32'd1);
        step();
        cfg_we = 1'b0;
        applyStimulus(4'b0100, 1'b1);
        checkOutput("t5_ready_b", 32'(req_ready), 32'b0100);
        pushExp(2'd2, 32'd9);
        step();
        applyStimulus(4'b0000, 1'b1);
        repeat (3) step();

        // Test 6: reset right after a handshake drops the response
        applyStimulus(4'b0001, 1'b1);
        checkOutput("t6_ready", 32'(req_ready), 32'b0001);
        step();
        applyStimulus(4'b0000, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_ready", 32'(req_ready), 32'd0);
        step();
        checkOutput("t6_no_resp", 32'(resp_valid), 32'd0);
        checkOutput("t6_clear_ctrl", 32'(driven_ctrl()), 32'hDB);
        step();
        rst_n     = 1'b1;
        exp_state = '0;
        step();
        step();
        applyStimulus(4'b1111, 1'b1);
        checkOutput("t6_ptr_reset", 32'(req_ready), 32'b0001);
        pushExp(2'd0, 32'd0);
        step();
        applyStimulus(4'b0000, 1'b1);
        writeCfg(2'd0, 32'd0, 32'd1, 8'hCB);
        applyStimulus(4'b0001, 1'b1);
        pushExp(2'd0, 32'd1);
        step();
        applyStimulus(4'b0000, 1'b1);
        repeat (4) step();

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
